// File: rtl/uart_rx_fifo_if.sv
// Signal bundle between the UART receiver/host logic and the receive FIFO.
// With UART_RX_TIMEOUT_EN defined the idle-timeout signals are added.
interface uart_rx_fifo_if #(
   parameter int ADDR_W = 4
);
   logic [7:0]      rx_data;
   logic            rx_data_valid;
   logic            rd_en;
   logic [7:0]      rd_data;
   logic            rd_data_valid;
   logic            clr_overrun;
   logic [ADDR_W:0] thresh;
   logic [ADDR_W:0] level;
   logic            empty;
   logic            full;
   logic            overrun;
   logic            thresh_irq;
`ifdef UART_RX_TIMEOUT_EN
   logic [15:0]     timeout_cycles;
   logic            rx_timeout;

   modport slave (
      input  rx_data, rx_data_valid, rd_en, clr_overrun, thresh, timeout_cycles,
      output rd_data, rd_data_valid, level, empty, full, overrun, thresh_irq, rx_timeout
   );
   modport master (
      output rx_data, rx_data_valid, rd_en, clr_overrun, thresh, timeout_cycles,
      input  rd_data, rd_data_valid, level, empty, full, overrun, thresh_irq, rx_timeout
   );
`else
   modport slave (
      input  rx_data, rx_data_valid, rd_en, clr_overrun, thresh,
      output rd_data, rd_data_valid, level, empty, full, overrun, thresh_irq
   );
   modport master (
      output rx_data, rx_data_valid, rd_en, clr_overrun, thresh,
      input  rd_data, rd_data_valid, level, empty, full, overrun, thresh_irq
   );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular byte FIFO behind the UART receiver: level/status, sticky overrun, threshold irq.
// Optional idle timeout (rx_timeout) is built when UART_RX_TIMEOUT_EN is defined.
module uart_rx_fifo #(
   parameter int DEPTH  = 16,
   parameter int ADDR_W = 4
) (
   input  logic           clk,
   input  logic           rst,
   uart_rx_fifo_if.slave  bus
);
   localparam logic [ADDR_W:0] LEVEL_FULL = (ADDR_W + 1)'(DEPTH);

   logic [7:0]        mem_q [DEPTH];
   logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]   level_q, level_d;
   logic [7:0]        rd_data_q, rd_data_d;
   logic              rd_data_valid_q, rd_data_valid_d;
   logic              overrun_q, overrun_d;
   logic              thresh_irq_q, thresh_irq_d;
   logic              empty, full;
   logic              wr_acc, rd_acc, ovr_set;

   assign empty = (level_q == '0);
   assign full  = (level_q == LEVEL_FULL);

   // A read frees a slot in the same cycle, so a write while full is still taken then.
   assign rd_acc  = bus.rd_en && !empty;
   assign wr_acc  = bus.rx_data_valid && (!full || rd_acc);
   assign ovr_set = bus.rx_data_valid && full && !rd_acc;

   always_comb begin
      wr_ptr_d        = wr_ptr_q;
      rd_ptr_d        = rd_ptr_q;
      level_d         = level_q;
      rd_data_d       = rd_data_q;
      rd_data_valid_d = rd_acc;
      overrun_d       = overrun_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + ADDR_W'(1);
      end
      if (rd_acc) begin
         rd_ptr_d  = rd_ptr_q + ADDR_W'(1);
         rd_data_d = mem_q[rd_ptr_q];
      end
      case ({wr_acc, rd_acc})
         2'b10:   level_d = level_q + (ADDR_W + 1)'(1);
         2'b01:   level_d = level_q - (ADDR_W + 1)'(1);
         default: level_d = level_q;
      endcase
      if (ovr_set) begin
         overrun_d = 1'b1;
      end else if (bus.clr_overrun) begin
         overrun_d = 1'b0;
      end
      thresh_irq_d = (bus.thresh != '0) && (level_d >= bus.thresh);
   end

   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q] <= bus.rx_data;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr_q        <= '0;
         rd_ptr_q        <= '0;
         level_q         <= '0;
         rd_data_q       <= 8'h00;
         rd_data_valid_q <= 1'b0;
         overrun_q       <= 1'b0;
         thresh_irq_q    <= 1'b0;
      end else begin
         wr_ptr_q        <= wr_ptr_d;
         rd_ptr_q        <= rd_ptr_d;
         level_q         <= level_d;
         rd_data_q       <= rd_data_d;
         rd_data_valid_q <= rd_data_valid_d;
         overrun_q       <= overrun_d;
         thresh_irq_q    <= thresh_irq_d;
      end
   end

   assign bus.rd_data       = rd_data_q;
   assign bus.rd_data_valid = rd_data_valid_q;
   assign bus.level         = level_q;
   assign bus.empty         = empty;
   assign bus.full          = full;
   assign bus.overrun       = overrun_q;
   assign bus.thresh_irq    = thresh_irq_q;

`ifdef UART_RX_TIMEOUT_EN
   logic [15:0] idle_cnt_q, idle_cnt_d;

   // Saturates at timeout_cycles so rx_timeout stays up until the FIFO is serviced.
   always_comb begin
      idle_cnt_d = idle_cnt_q;
      if (wr_acc || rd_acc || empty) begin
         idle_cnt_d = '0;
      end else if (idle_cnt_q < bus.timeout_cycles) begin
         idle_cnt_d = idle_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idle_cnt_q <= '0;
      end else begin
         idle_cnt_q <= idle_cnt_d;
      end
   end

   assign bus.rx_timeout = (bus.timeout_cycles != '0) && (idle_cnt_q == bus.timeout_cycles) && !empty;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (timeout checks only with UART_RX_TIMEOUT_EN).
module tb_uart_rx_fifo;
   localparam int DEPTH  = 16;
   localparam int ADDR_W = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks   = 0;
   int   failures = 0;

   uart_rx_fifo_if #(.ADDR_W(ADDR_W)) bus ();

   uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [7:0] b);
      bus.rx_data       = b;
      bus.rx_data_valid = 1'b1;
      tick();
      bus.rx_data_valid = 1'b0;
   endtask

   task automatic rd_chk(input string tag, input logic [7:0] exp);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk({tag, "_vld"}, 32'(bus.rd_data_valid), 32'd1);
      chk({tag, "_dat"}, 32'(bus.rd_data), 32'(exp));
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      tick();
   endtask

   initial begin
      bus.rx_data       = 8'h00;
      bus.rx_data_valid = 1'b0;
      bus.rd_en         = 1'b0;
      bus.clr_overrun   = 1'b0;
      bus.thresh        = '0;
`ifdef UART_RX_TIMEOUT_EN
      bus.timeout_cycles = 16'd0;
`endif
      do_reset();
      chk("rst_level", 32'(bus.level), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_full", 32'(bus.full), 32'd0);
      chk("rst_ovr", 32'(bus.overrun), 32'd0);
      chk("rst_irq", 32'(bus.thresh_irq), 32'd0);
      chk("rst_rdd", 32'(bus.rd_data), 32'd0);
      chk("rst_rdv", 32'(bus.rd_data_valid), 32'd0);

      // basic write/read with 1-cycle latency
      wr(8'hA5);
      wr(8'h3C);
      chk("t1_level2", 32'(bus.level), 32'd2);
      rd_chk("t1_rd0", 8'hA5);
      rd_chk("t1_rd1", 8'h3C);
      tick();
      chk("t1_vld_drop", 32'(bus.rd_data_valid), 32'd0);
      chk("t1_hold", 32'(bus.rd_data), 32'h3C);
      chk("t1_level0", 32'(bus.level), 32'd0);
      chk("t1_empty", 32'(bus.empty), 32'd1);
      bus.rd_en = 1'b1;
      tick();
      bus.rd_en = 1'b0;
      chk("t1_rd_empty_vld", 32'(bus.rd_data_valid), 32'd0);
      chk("t1_rd_empty_lvl", 32'(bus.level), 32'd0);

      // fill, overrun, drain, clear
      for (int i = 0; i < 16; i++) wr(8'(i));
      chk("t2_full", 32'(bus.full), 32'd1);
      chk("t2_no_ovr_yet", 32'(bus.overrun), 32'd0);
      wr(8'hFF);
      chk("t2_ovr", 32'(bus.overrun), 32'd1);
      chk("t2_level", 32'(bus.level), 32'd16);
      for (int i = 0; i < 16; i++) rd_chk($sformatf("t2_rd%0d", i), 8'(i));
      chk("t2_empty", 32'(bus.empty), 32'd1);
      chk("t2_ovr_sticky", 32'(bus.overrun), 32'd1);
      bus.clr_overrun = 1'b1;
      tick();
      bus.clr_overrun = 1'b0;
      chk("t2_ovr_clr", 32'(bus.overrun), 32'd0);

      // simultaneous write+read while full
      for (int i = 0; i < 16; i++) wr(8'h10 + 8'(i));
      bus.rx_data       = 8'h77;
      bus.rx_data_valid = 1'b1;
      bus.rd_en         = 1'b1;
      tick();
      bus.rx_data_valid = 1'b0;
      bus.rd_en         = 1'b0;
      chk("t3_vld", 32'(bus.rd_data_valid), 32'd1);
      chk("t3_dat", 32'(bus.rd_data), 32'h10);
      chk("t3_level", 32'(bus.level), 32'd16);
      chk("t3_ovr", 32'(bus.overrun), 32'd0);
      for (int i = 1; i < 16; i++) rd_chk($sformatf("t3_rd%0d", i), 8'h10 + 8'(i));
      rd_chk("t3_last", 8'h77);
      chk("t3_empty", 32'(bus.empty), 32'd1);

      // threshold interrupt
      bus.thresh = 5'd4;
      tick();
      for (int i = 0; i < 3; i++) wr(8'h40 + 8'(i));
      chk("t4_irq_3", 32'(bus.thresh_irq), 32'd0);
      wr(8'h43);
      chk("t4_irq_4", 32'(bus.thresh_irq), 32'd1);
      rd_chk("t4_rd", 8'h40);
      chk("t4_irq_after_rd", 32'(bus.thresh_irq), 32'd0);
      for (int i = 0; i < 13; i++) wr(8'h50 + 8'(i));
      chk("t4_level16", 32'(bus.level), 32'd16);
      chk("t4_irq_16", 32'(bus.thresh_irq), 32'd1);
      bus.thresh = '0;
      tick();
      chk("t4_irq_dis", 32'(bus.thresh_irq), 32'd0);

      // async reset mid-stream
      do_reset();
      for (int i = 0; i < 5; i++) wr(8'h60 + 8'(i));
      rd_chk("t5_rd0", 8'h60);
      bus.rd_en = 1'b1;
      tick();
      chk("t5_rd1", 32'(bus.rd_data), 32'h61);
      wr(8'hEE);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("t5_rst_level", 32'(bus.level), 32'd0);
      chk("t5_rst_empty", 32'(bus.empty), 32'd1);
      chk("t5_rst_ovr", 32'(bus.overrun), 32'd0);
      chk("t5_rst_vld", 32'(bus.rd_data_valid), 32'd0);
      bus.rd_en = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      // write with read on empty FIFO: write only, no bypass
      bus.rx_data       = 8'h5A;
      bus.rx_data_valid = 1'b1;
      bus.rd_en         = 1'b1;
      tick();
      bus.rx_data_valid = 1'b0;
      bus.rd_en         = 1'b0;
      chk("t5_nobypass_vld", 32'(bus.rd_data_valid), 32'd0);
      chk("t5_level1", 32'(bus.level), 32'd1);
      rd_chk("t5_rd5a", 8'h5A);

`ifdef UART_RX_TIMEOUT_EN
      bus.timeout_cycles = 16'd10;
      wr(8'h99);
      for (int i = 0; i < 9; i++) tick();
      chk("t6_to_early", 32'(bus.rx_timeout), 32'd0);
      tick();
      chk("t6_to_set", 32'(bus.rx_timeout), 32'd1);
      tick();
      chk("t6_to_hold", 32'(bus.rx_timeout), 32'd1);
      rd_chk("t6_rd", 8'h99);
      chk("t6_to_clr", 32'(bus.rx_timeout), 32'd0);
      bus.timeout_cycles = 16'd0;
      wr(8'h98);
      for (int i = 0; i < 20; i++) tick();
      chk("t6_to_dis", 32'(bus.rx_timeout), 32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
